// File: rtl/scan_capture.sv
// scan_capture: rebuilds an 8-digit hex/point/LE frame from a 7-seg scan stream.
// Optional macro SCAN_CAPTURE_CHANGE_EN builds the frame_changed compare logic.
module scan_capture #(
   parameter int ERR_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 sample,
   input  logic [3:0]           Hexo,
   input  logic [3:0]           AN,
   input  logic                 scan_hi,
   input  logic                 p,
   input  logic                 LE,
   output logic [31:0]          Hexs,
   output logic [7:0]           point,
   output logic [7:0]           LES,
   output logic                 frame_valid,
   output logic                 frame_changed,
   output logic                 locked,
   output logic                 sync_err,
   output logic [ERR_CNT_W-1:0] err_cnt
);
   typedef enum logic {HUNT, CAPTURE} state_e;

   state_e                state_q, state_d;
   logic [2:0]            idx_q, idx_d;
   logic [31:0]           sh_hex_q, sh_hex_d;
   logic [7:0]            sh_p_q, sh_p_d;
   logic [7:0]            sh_le_q, sh_le_d;
   logic [31:0]           hexs_q, hexs_d;
   logic [7:0]            point_q, point_d;
   logic [7:0]            les_q, les_d;
   logic                  fv_q, fv_d;
   logic                  err_q, err_d;
   logic [ERR_CNT_W-1:0]  cnt_q, cnt_d;
   logic                  an_ok;
   logic [1:0]            lane;
   logic [2:0]            d;
   logic                  wr_en;
   logic                  commit;

   always_comb begin
      an_ok = 1'b1;
      lane  = 2'd0;
      case (AN)
         4'b1110: lane = 2'd0;
         4'b1101: lane = 2'd1;
         4'b1011: lane = 2'd2;
         4'b0111: lane = 2'd3;
         default: an_ok = 1'b0;
      endcase
      d = {scan_hi, lane};
   end

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      sh_hex_d = sh_hex_q;
      sh_p_d   = sh_p_q;
      sh_le_d  = sh_le_q;
      hexs_d   = hexs_q;
      point_d  = point_q;
      les_d    = les_q;
      fv_d     = 1'b0;
      err_d    = 1'b0;
      wr_en    = 1'b0;
      commit   = 1'b0;
      if (sample) begin
         if (state_q == HUNT) begin
            if (!an_ok) begin
               err_d = 1'b1;
            end else if (d == 3'd0) begin
               wr_en   = 1'b1;
               idx_d   = 3'd1;
               state_d = CAPTURE;
            end
         end else if (an_ok && d == idx_q) begin
            wr_en  = 1'b1;
            idx_d  = idx_q + 3'd1;
            commit = (idx_q == 3'd7);
         end else begin
            err_d = 1'b1;
            // A clean digit 0 doubles as the start of a fresh frame
            if (an_ok && d == 3'd0) begin
               wr_en = 1'b1;
               idx_d = 3'd1;
            end else begin
               state_d = HUNT;
               idx_d   = 3'd0;
            end
         end
      end
      if (wr_en) begin
         sh_hex_d[{d, 2'b00} +: 4] = Hexo;
         sh_p_d[d]                 = p;
         sh_le_d[d]                = LE;
      end
      if (commit) begin
         hexs_d  = sh_hex_d;
         point_d = sh_p_d;
         les_d   = sh_le_d;
         fv_d    = 1'b1;
      end
      cnt_d = cnt_q;
      if (err_d && cnt_q != '1) cnt_d = cnt_q + ERR_CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= HUNT;
         idx_q    <= 3'd0;
         sh_hex_q <= 32'd0;
         sh_p_q   <= 8'd0;
         sh_le_q  <= 8'd0;
         hexs_q   <= 32'd0;
         point_q  <= 8'd0;
         les_q    <= 8'd0;
         fv_q     <= 1'b0;
         err_q    <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         sh_hex_q <= sh_hex_d;
         sh_p_q   <= sh_p_d;
         sh_le_q  <= sh_le_d;
         hexs_q   <= hexs_d;
         point_q  <= point_d;
         les_q    <= les_d;
         fv_q     <= fv_d;
         err_q    <= err_d;
         cnt_q    <= cnt_d;
      end
   end

`ifdef SCAN_CAPTURE_CHANGE_EN
   logic seen_q, seen_d;
   logic chg_q, chg_d;

   // The committed outputs double as the previous-frame compare register
   always_comb begin
      seen_d = seen_q | commit;
      chg_d  = commit &&
               (!seen_q || {hexs_d, point_d, les_d} != {hexs_q, point_q, les_q});
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seen_q <= 1'b0;
         chg_q  <= 1'b0;
      end else begin
         seen_q <= seen_d;
         chg_q  <= chg_d;
      end
   end

   assign frame_changed = chg_q;
`else
   assign frame_changed = 1'b0;
`endif

   assign Hexs        = hexs_q;
   assign point       = point_q;
   assign LES         = les_q;
   assign frame_valid = fv_q;
   assign locked      = (state_q == CAPTURE);
   assign sync_err    = err_q;
   assign err_cnt     = cnt_q;
endmodule

// File: tb/tb_scan_capture.sv
// tb_scan_capture: directed + random scan streams checked against a digit-array model.
module tb_scan_capture;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        sample = 1'b0;
   logic [3:0]  Hexo = 4'd0;
   logic [3:0]  AN = 4'hF;
   logic        scan_hi = 1'b0;
   logic        p = 1'b0;
   logic        LE = 1'b0;
   logic [31:0] Hexs;
   logic [7:0]  point;
   logic [7:0]  LES;
   logic        frame_valid;
   logic        frame_changed;
   logic        locked;
   logic        sync_err;
   logic [7:0]  err_cnt;

   int n_chk = 0;
   int n_pass = 0;

   scan_capture #(.ERR_CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .sample(sample), .Hexo(Hexo),
      .AN(AN), .scan_hi(scan_hi), .p(p), .LE(LE),
      .Hexs(Hexs), .point(point), .LES(LES),
      .frame_valid(frame_valid), .frame_changed(frame_changed),
      .locked(locked), .sync_err(sync_err), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   // reference model: receiver expectation plus per-digit storage arrays
   bit          m_lock;
   int          m_next;
   logic [3:0]  s_hex[8];
   bit          s_p[8];
   bit          s_le[8];
   logic [31:0] m_hexs;
   logic [7:0]  m_point, m_les;
   bit          m_fv, m_se, m_fc, m_have;
   int          m_errs;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
   endtask

   function automatic int lane_of(input logic [3:0] an);
      case (an)
         4'hE: return 0;
         4'hD: return 1;
         4'hB: return 2;
         4'h7: return 3;
         default: return -1;
      endcase
   endfunction

   task automatic model_reset();
      m_lock = 0; m_next = 0; m_hexs = 0; m_point = 0; m_les = 0;
      m_fv = 0; m_se = 0; m_fc = 0; m_have = 0; m_errs = 0;
      for (int i = 0; i < 8; i++) begin
         s_hex[i] = 0; s_p[i] = 0; s_le[i] = 0;
      end
   endtask

   task automatic store(input int d, input logic [3:0] h,
                        input bit pp, input bit le);
      s_hex[d] = h; s_p[d] = pp; s_le[d] = le;
   endtask

   task automatic model_step(input bit s, input logic [3:0] an,
                             input bit hi, input logic [3:0] h,
                             input bit pp, input bit le);
      int ln, d;
      logic [31:0] nh;
      logic [7:0]  np, nl;
      m_fv = 0; m_se = 0; m_fc = 0;
      if (!s) return;
      ln = lane_of(an);
      d = (hi ? 4 : 0) + ln;
      if (!m_lock) begin
         if (ln < 0) begin
            m_se = 1; m_errs++;
         end else if (d == 0) begin
            store(0, h, pp, le); m_next = 1; m_lock = 1;
         end
      end else if (ln >= 0 && d == m_next) begin
         store(d, h, pp, le);
         if (m_next == 7) begin
            nh = 0; np = 0; nl = 0;
            for (int i = 0; i < 8; i++) begin
               nh = nh + (32'(s_hex[i]) << (4 * i));
               np = np + (8'(s_p[i]) << i);
               nl = nl + (8'(s_le[i]) << i);
            end
`ifdef SCAN_CAPTURE_CHANGE_EN
            m_fc = !m_have || {nh, np, nl} != {m_hexs, m_point, m_les};
`endif
            m_have = 1; m_hexs = nh; m_point = np; m_les = nl;
            m_fv = 1; m_next = 0;
         end else begin
            m_next++;
         end
      end else begin
         m_se = 1; m_errs++;
         if (ln >= 0 && d == 0) begin
            store(0, h, pp, le); m_next = 1;
         end else begin
            m_lock = 0; m_next = 0;
         end
      end
   endtask

   task automatic check_all();
      chk("hexs", Hexs, m_hexs);
      chk("point", point, m_point);
      chk("les", LES, m_les);
      chk("frame_valid", frame_valid, m_fv);
      chk("frame_changed", frame_changed, m_fc);
      chk("locked", locked, m_lock);
      chk("sync_err", sync_err, m_se);
      chk("err_cnt", err_cnt, (m_errs > 255) ? 255 : m_errs);
   endtask

   task automatic step(input bit s, input logic [3:0] an, input bit hi,
                       input logic [3:0] h, input bit pp, input bit le);
      @(negedge clk);
      sample = s; AN = an; scan_hi = hi; Hexo = h; p = pp; LE = le;
      model_step(s, an, hi, h, pp, le);
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic dig(input int d, input logic [3:0] h,
                      input bit pp, input bit le);
      step(1'b1, ~(4'b0001 << d[1:0]), d[2], h, pp, le);
   endtask

   task automatic idle();
      step(1'b0, 4'hF, 1'b0, 4'h0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      sample = 1'b0;
      #1;
      model_reset();
      check_all();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic send_frame(input logic [31:0] hx, input logic [7:0] pt,
                             input logic [7:0] le);
      for (int i = 0; i < 8; i++) dig(i, hx[4*i +: 4], pt[i], le[i]);
   endtask

   logic [31:0] prev;

   initial begin
      model_reset();
      do_reset();

      send_frame(32'h87654321, 8'h08, 8'h80);
      chk("clean_hexs", Hexs, 32'h87654321);
      chk("clean_point", point, 8'h08);
      chk("clean_les", LES, 8'h80);
      chk("clean_fv", frame_valid, 1'b1);
      chk("clean_locked", locked, 1'b1);
      idle();
      chk("clean_fv_once", frame_valid, 1'b0);

      do_reset();
      for (int d = 5; d < 8; d++) dig(d, 4'(d), 1'b0, 1'b0);
      chk("hunt_no_lock", locked, 1'b0);
      send_frame(32'hA1B2C3D4, 8'h55, 8'hAA);
      chk("hunt_hexs", Hexs, 32'hA1B2C3D4);
      chk("hunt_err_cnt", err_cnt, 8'd0);

      prev = Hexs;
      dig(0, 4'h1, 1'b0, 1'b0);
      dig(1, 4'h2, 1'b0, 1'b0);
      dig(2, 4'h3, 1'b0, 1'b0);
      dig(4, 4'h5, 1'b0, 1'b0);
      chk("skip_sync_err", sync_err, 1'b1);
      chk("skip_err_cnt", err_cnt, 8'd1);
      chk("skip_unlocked", locked, 1'b0);
      chk("skip_hexs_kept", Hexs, prev);
      send_frame(32'h0F1E2D3C, 8'h01, 8'h02);
      chk("skip_recover", Hexs, 32'h0F1E2D3C);

      dig(0, 4'h9, 1'b0, 1'b0);
      dig(1, 4'h9, 1'b0, 1'b0);
      step(1'b1, 4'hF, 1'b0, 4'h9, 1'b0, 1'b0);
      chk("badan_err", sync_err, 1'b1);
      chk("badan_hunt", locked, 1'b0);
      dig(0, 4'h1, 1'b0, 1'b0);
      dig(1, 4'h2, 1'b0, 1'b0);
      dig(2, 4'h3, 1'b0, 1'b0);
      dig(0, 4'hC, 1'b1, 1'b0);
      chk("restart_err", sync_err, 1'b1);
      chk("restart_locked", locked, 1'b1);
      for (int i = 1; i < 8; i++) dig(i, 4'(i), 1'b0, 1'b1);
      chk("restart_hexs", Hexs, 32'h7654321C);
      chk("restart_point", point, 8'h01);
      chk("restart_les", LES, 8'hFE);

      for (int i = 0; i < 4; i++) dig(i, 4'hE, 1'b1, 1'b1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all();
      chk("rst_hexs", Hexs, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      send_frame(32'h13579BDF, 8'h80, 8'h01);
      chk("post_rst_hexs", Hexs, 32'h13579BDF);

      send_frame(32'h12345678, 8'h00, 8'h00);
      send_frame(32'h12345678, 8'h00, 8'h00);
      send_frame(32'h12345678, 8'h10, 8'h00);

      begin
         int gen, r, d;
         bit s;
         logic [3:0] an;
         logic [3:0] bad[4];
         bad[0] = 4'hF; bad[1] = 4'hC; bad[2] = 4'h0; bad[3] = 4'h5;
         gen = 0;
         for (int n = 0; n < 1500; n++) begin
            s = ($urandom_range(0, 9) != 0);
            r = $urandom_range(0, 99);
            d = (r < 8) ? $urandom_range(0, 7) : gen;
            an = ~(4'b0001 << d[1:0]);
            if (r < 3) an = bad[$urandom_range(0, 3)];
            step(s, an, d[2], 4'($urandom), 1'($urandom), 1'($urandom));
            if (s) gen = (d + 1) % 8;
         end
      end

      for (int n = 0; n < 300; n++) step(1'b1, 4'hF, 1'b0, 4'h0, 1'b0, 1'b0);
      chk("err_sat", err_cnt, 8'hFF);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/scan_capture.md
Name: scan_capture

Overview:
- Receiver for the multiplexed 7-segment scan stream produced by the display scan-sync mux.
- Observes one digit per scan step (nibble, anode select, point, LE) and rebuilds the full 8-digit frame as Hexs[31:0], point[7:0] and LES[7:0].
- Used for self-check, display loop-back, and for feeding the captured value back to the ALU framework debug path.

Parameters:
- ERR_CNT_W, 8, width of the saturating sync-error counter.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- sample  input  1  one-cycle strobe; scan inputs are stable and valid this cycle.
- Hexo  input  4  digit nibble of the current scan step.
- AN  input  4  anode select, active-low one-hot: 1110, 1101, 1011, 0111 = lane 0..3.
- scan_hi  input  1  Scan[2] of the transmitter; selects digits 0-3 (0) or 4-7 (1).
- p  input  1  decimal-point bit of the current digit.
- LE  input  1  latch-enable bit of the current digit.
- Hexs  output  32  last committed frame; digit i occupies [4i+3:4i].
- point  output  8  last committed point bits; bit i = digit i.
- LES  output  8  last committed LE bits; bit i = digit i.
- frame_valid  output  1  one-cycle pulse when a new frame is committed.
- frame_changed  output  1  one-cycle pulse; see Optional Feature.
- locked  output  1  high while the FSM is in CAPTURE.
- sync_err  output  1  one-cycle pulse on a sequence or encoding error.
- err_cnt  output  ERR_CNT_W  saturating count of sync_err pulses.

Behaviour:
- Reset: all outputs 0 and state HUNT; internal shadow frame and digit index idx[2:0] cleared.
- Inputs are evaluated only on cycles with sample=1; all other cycles hold state.
- Digit decode: d = {scan_hi, lane(AN)}. An AN value that is not one-hot-low (e.g. 1111, 1100, 0000) is an encoding error.
- State HUNT:
  - Sample with d=0 → store digit 0 into the shadow, set idx=1, go to CAPTURE. locked goes high on the next cycle.
  - Any other valid sample is ignored silently; no sync_err is raised in HUNT.
  - An encoding error in HUNT → sync_err pulse and err_cnt increment; stay in HUNT.
- State CAPTURE (expects d == idx):
  - Match, idx<7: store Hexo/p/LE into shadow digit idx; idx ← idx+1.
  - Match, idx==7: store digit 7, then on the same edge copy the complete shadow (including digit 7) to Hexs/point/LES. frame_valid=1 for exactly the following cycle; idx ← 0; stay in CAPTURE.
  - Mismatch or encoding error: sync_err pulse and err_cnt increment. Shadow is discarded and outputs keep the previous frame.
    - If the offending sample has d=0 and valid AN, it restarts capture (store digit 0, idx=1, stay in CAPTURE).
    - Otherwise go to HUNT; locked falls the next cycle.
- Latency: outputs update on the clock edge that samples digit 7, so frame_valid is visible 1 cycle after the digit-7 sample.
- Outputs never show a partial frame. Digits are committed all-or-nothing.
- err_cnt saturates at 2^ERR_CNT_W-1 and clears only on reset.
- Reset mid-frame: immediate return to the reset values; the partial frame is lost.
- Back-to-back samples (sample held high every cycle) are fully supported; there are no bubbles between frames.

Optional Feature:
- Macro SCAN_CAPTURE_CHANGE_EN.
- Defined: a compare register holds the previous committed frame {Hexs, point, LES}. frame_changed pulses together with frame_valid only when the new 48-bit frame differs from the previous one. The first frame after reset always counts as changed.
- Undefined: no compare logic is built and frame_changed is tied to 0.

Test Plan:
- Clean frame: reset, then 8 samples d=0..7 carrying nibbles 1..8, p=1 on digit 3, LE=1 on digit 7 → Hexs=32'h87654321, point=8'h08, LES=8'h80; frame_valid pulses once, 1 cycle after the last sample; locked=1.
- Hunt alignment: start the stream at d=5 (5,6,7,0..7) → no sync_err; the frame commits after the second digit 7; err_cnt=0.
- Skipped digit: sequence 0,1,2,4 → sync_err on the d=4 sample, err_cnt=1, state HUNT, Hexs unchanged; the next full 0..7 commits correctly.
- Bad anode: AN=1111 mid-frame → sync_err, HUNT. AN=1110 with scan_hi=0 mid-frame → restart; the next 1..7 commits the frame.
- Reset mid-frame: assert rst_n=0 after 4 samples → all outputs 0 asynchronously; after release, a full frame commits normally.
- With SCAN_CAPTURE_CHANGE_EN: send two identical frames, then one differing in a single point bit → frame_changed pulses on frames 1 and 3 only; frame_valid pulses on all 3.
